// File: rtl/spi_slave_gen.sv
// SPI slave front-end for the single-port RAM: deserialises {cmd,payload} frames from MOSI
// and serialises RAM read data onto MISO, flagging aborted frames and read-data timeouts.
module spi_slave_gen #(
    parameter int PAYLOAD_W  = 8,
    parameter int DATA_W     = 8,
    parameter int LSB_FIRST  = 0,
    parameter int TX_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic                 rx_valid,
    output logic [PAYLOAD_W+1:0] rx_data,
    input  logic                 tx_valid,
    input  logic [DATA_W-1:0]    tx_data,
    output logic                 busy,
    output logic                 frame_err
);
    localparam int RX_W  = PAYLOAD_W + 2;
    localparam int MAX_A = (RX_W > DATA_W) ? RX_W : DATA_W;
    localparam int MAX_V = (MAX_A > TX_TIMEOUT) ? MAX_A : TX_TIMEOUT;
    localparam int CW    = $clog2(MAX_V + 1);

    localparam logic [CW-1:0] RX_LAST   = CW'(RX_W - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TX_TIMEOUT - 1);
    localparam logic [CW-1:0] TX_BITS   = CW'(DATA_W);

    typedef enum logic [2:0] {
        IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, RD_WAIT, RD_TX, DONE
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [1:0]           cmd;
    logic [PAYLOAD_W-1:0] pay;
    logic [PAYLOAD_W-1:0] pay_nx;
    logic [DATA_W-1:0]    tx_sr;
    logic                 rd_addr_ok;

    // Payload shifts in from the end matching the wire order, so rx_data is always {cmd, payload}.
    always_comb begin
        if (LSB_FIRST != 0) pay_nx = {MOSI, pay[PAYLOAD_W-1:1]};
        else                pay_nx = {pay[PAYLOAD_W-2:0], MOSI};
    end

    function automatic logic tx_bit(input logic [DATA_W-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] w);
        return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
    endfunction

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            cmd        <= '0;
            pay        <= '0;
            tx_sr      <= '0;
            rd_addr_ok <= 1'b0;
            MISO       <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            MISO      <= 1'b0;
            // Deselect wins over everything, including a frame completing on this edge.
            if (state != IDLE && SS_n) begin
                state <= IDLE;
                cnt   <= '0;
                if (state inside {CHK_CMD, WRITE, READ_ADD, READ_DATA, RD_TX}) frame_err <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (!SS_n) begin
                            state <= CHK_CMD;
                            cnt   <= '0;
                        end
                    end
                    CHK_CMD: begin
                        cmd[1] <= MOSI;
                        cnt    <= CW'(1);
                        if (!MOSI)           state <= WRITE;
                        else if (rd_addr_ok) state <= READ_DATA;
                        else                 state <= READ_ADD;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(1)) cmd[0] <= MOSI;
                        else               pay    <= pay_nx;
                        if (cnt == RX_LAST) begin
                            rx_valid <= 1'b1;
                            rx_data  <= {cmd, pay_nx};
                            cnt      <= '0;
                            if (cmd == 2'b10)      rd_addr_ok <= 1'b1;
                            else if (cmd == 2'b11) rd_addr_ok <= 1'b0;
                            state <= (state == READ_DATA && cmd == 2'b11) ? RD_WAIT : DONE;
                        end
                    end
                    RD_WAIT: begin
                        if (tx_valid) begin
                            MISO  <= tx_bit(tx_data);
                            tx_sr <= tx_shift(tx_data);
                            cnt   <= CW'(1);
                            state <= RD_TX;
                        end else if (cnt == WAIT_LAST) begin
                            frame_err <= 1'b1;
                            cnt       <= '0;
                            state     <= DONE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    RD_TX: begin
                        if (cnt == TX_BITS) begin
                            cnt   <= '0;
                            state <= DONE;
                        end else begin
                            MISO  <= tx_bit(tx_sr);
                            tx_sr <= tx_shift(tx_sr);
                            cnt   <= cnt + CW'(1);
                        end
                    end
                    DONE: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_gen.sv
// Bench for spi_slave_gen: transaction-level timeline model for the default build,
// plus directed LSB-first checks on a wide-payload build.
module tb_spi_slave_gen;
    localparam int PW = 8, DW = 8, TO = 16, RXW = PW + 2;
    localparam int PW2 = 10, DW2 = 16, RXW2 = PW2 + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic ss_n = 1'b1, mosi = 1'b0, tx_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic miso, rx_valid, busy, frame_err;
    logic [RXW-1:0] rx_data;

    logic ss_n2 = 1'b1, mosi2 = 1'b0, tx_valid2 = 1'b0;
    logic [DW2-1:0] tx_data2 = '0;
    logic miso2, rx_valid2, busy2, frame_err2;
    logic [RXW2-1:0] rx_data2;

    int total = 0, bad = 0;
    logic chk_en = 1'b0;
    logic e_miso = 1'b0, e_rxv = 1'b0, e_busy = 1'b0, e_ferr = 1'b0;
    logic [RXW-1:0] e_rxd = '0, m_rx_data = '0;
    logic m_rd_ok = 1'b0;
    logic [31:0] rd_log, ferr_log;
    int b_ferr_cnt = 0;

    spi_slave_gen #(.PAYLOAD_W(PW), .DATA_W(DW), .LSB_FIRST(0), .TX_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .MOSI(mosi), .MISO(miso),
        .rx_valid(rx_valid), .rx_data(rx_data), .tx_valid(tx_valid), .tx_data(tx_data),
        .busy(busy), .frame_err(frame_err));

    spi_slave_gen #(.PAYLOAD_W(PW2), .DATA_W(DW2), .LSB_FIRST(1), .TX_TIMEOUT(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n2), .MOSI(mosi2), .MISO(miso2),
        .rx_valid(rx_valid2), .rx_data(rx_data2), .tx_valid(tx_valid2), .tx_data(tx_data2),
        .busy(busy2), .frame_err(frame_err2));

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("miso", 32'(miso), 32'(e_miso));
            cmp("rx_valid", 32'(rx_valid), 32'(e_rxv));
            cmp("rx_data", 32'(rx_data), 32'(e_rxd));
            cmp("busy", 32'(busy), 32'(e_busy));
            cmp("frame_err", 32'(frame_err), 32'(e_ferr));
        end
    end

    // One clock: apply inputs, then publish what the outputs must be after this edge.
    task automatic cyc(input logic ss, input logic md, input logic tv, input logic [DW-1:0] td,
                       input logic em, input logic ev, input logic eb, input logic ef,
                       input logic [RXW-1:0] erx);
        ss_n = ss; mosi = md; tx_valid = tv; tx_data = td;
        @(posedge clk); #1;
        e_miso = em; e_rxv = ev; e_busy = eb; e_ferr = ef; e_rxd = erx;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b1, 1'($urandom), 1'($urandom), DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, m_rx_data);
    endtask

    // A whole transaction: select, RXW bits (or abort after abort_bits), hold cycles, release.
    // For a read-data frame tx_valid comes d cycles after completion and carries word.
    task automatic frame(input logic [1:0] cmd, input logic [PW-1:0] pay, input int abort_bits,
                         input int d, input int hold, input logic [DW-1:0] word, input bit no_rel);
        logic [RXW-1:0] bits;
        logic rd_wait, em, ef, tv;
        logic [DW-1:0] td;
        bits = {cmd, pay};
        rd_log = '0; ferr_log = '0;
        cyc(1'b0, 1'($urandom), 1'($urandom), DW'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, m_rx_data);
        if (abort_bits < RXW) begin
            for (int i = 0; i < abort_bits; i++)
                cyc(1'b0, bits[RXW-1-i], 1'($urandom), DW'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, m_rx_data);
            cyc(1'b1, 1'($urandom), 1'($urandom), DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, m_rx_data);
            idle(1 + int'($urandom_range(0, 2)));
            return;
        end
        rd_wait = m_rd_ok && (cmd == 2'b11);
        for (int i = 0; i < RXW - 1; i++)
            cyc(1'b0, bits[RXW-1-i], 1'($urandom), DW'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, m_rx_data);
        m_rx_data = bits;
        cyc(1'b0, bits[0], 1'($urandom), DW'($urandom), 1'b0, 1'b1, 1'b1, 1'b0, m_rx_data);
        if (cmd == 2'b10) m_rd_ok = 1'b1;
        else if (cmd == 2'b11) m_rd_ok = 1'b0;
        for (int j = 1; j <= hold; j++) begin
            tv = 1'($urandom); td = DW'($urandom); em = 1'b0; ef = 1'b0;
            if (rd_wait) begin
                if (j < d) tv = 1'b0;
                if (j == d) begin tv = 1'b1; td = word; end
                if (d <= TO && j >= d && j < d + DW) em = word[DW-1-(j-d)];
                if (d > TO && j == TO) ef = 1'b1;
            end
            cyc(1'b0, 1'($urandom), tv, td, em, 1'b0, 1'b1, ef, m_rx_data);
            rd_log = {rd_log[30:0], miso};
            ferr_log = {ferr_log[30:0], frame_err};
        end
        if (no_rel) return;
        ef = rd_wait && (d <= TO) && (hold >= d) && (hold < d + DW);
        cyc(1'b1, 1'($urandom), 1'($urandom), DW'($urandom), 1'b0, 1'b0, 1'b0, ef, m_rx_data);
        idle(1 + int'($urandom_range(0, 2)));
    endtask

    task automatic cyc2(input logic ss, input logic md, input logic tv, input logic [DW2-1:0] td);
        ss_n2 = ss; mosi2 = md; tx_valid2 = tv; tx_data2 = td;
        @(posedge clk); #1;
        if (frame_err2) b_ferr_cnt++;
    endtask

    task automatic frame2(input logic [1:0] cmd, input logic [PW2-1:0] pay, input logic [DW2-1:0] word,
                          output logic [DW2-1:0] mlog, output int nval, output logic tail);
        nval = 0; mlog = '0;
        cyc2(1'b0, 1'b0, 1'b0, '0);
        cyc2(1'b0, cmd[1], 1'b0, '0);
        if (rx_valid2) nval++;
        cyc2(1'b0, cmd[0], 1'b0, '0);
        if (rx_valid2) nval++;
        for (int i = 0; i < PW2; i++) begin
            cyc2(1'b0, pay[i], 1'b0, '0);
            if (rx_valid2) nval++;
        end
        cyc2(1'b0, 1'b0, 1'b1, word);
        if (rx_valid2) nval++;
        mlog[0] = miso2;
        for (int i = 1; i < DW2; i++) begin
            cyc2(1'b0, 1'b1, 1'b1, ~word);
            mlog[i] = miso2;
        end
        cyc2(1'b0, 1'b0, 1'b0, '0);
        tail = miso2;
        cyc2(1'b1, 1'b0, 1'b0, '0);
        cyc2(1'b1, 1'b0, 1'b0, '0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW2-1:0] ml, w;
        int nv;
        logic tl;
        logic [1:0] c;
        int ab, d, hold;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp("reset_miso", 32'(miso), 32'd0);
        cmp("reset_rx_valid", 32'(rx_valid), 32'd0);
        cmp("reset_rx_data", 32'(rx_data), 32'd0);
        cmp("reset_busy", 32'(busy), 32'd0);
        cmp("reset_frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // Write frame 00_1010_0101
        frame(2'b00, 8'hA5, RXW, 1, 3, 8'h00, 1'b0);
        cmp("t1_rx_data", 32'(rx_data), 32'h0A5);

        // Read pair, tx_valid three cycles after the read-data frame
        frame(2'b10, 8'h30, RXW, 1, 2, 8'h00, 1'b0);
        cmp("t2_addr_rx_data", 32'(rx_data), 32'h230);
        frame(2'b11, 8'h00, RXW, 3, 13, 8'hC3, 1'b0);
        cmp("t2_data_rx_data", 32'(rx_data), 32'h300);
        cmp("t2_miso_seq", 32'(rd_log[12:0]), 32'h0618);

        // Abort after 5 bits of a write frame
        frame(2'b00, 8'h5A, 5, 1, 0, 8'h00, 1'b0);
        cmp("t3_rx_data_held", 32'(rx_data), 32'h300);

        // Timeout: tx_valid arrives too late (cycle 19)
        frame(2'b10, 8'h07, RXW, 1, 1, 8'h00, 1'b0);
        frame(2'b11, 8'h00, RXW, TO + 3, 22, 8'hFF, 1'b0);
        cmp("t4_ferr_at_16", ferr_log, 32'h40);
        cmp("t4_miso_quiet", rd_log, 32'h0);

        // Async reset in the middle of RD_TX
        frame(2'b10, 8'h11, RXW, 1, 1, 8'h00, 1'b0);
        frame(2'b11, 8'h22, RXW, 1, 2, 8'hC3, 1'b1);
        cmp("t5_miso_before", 32'(miso), 32'd1);
        #2 chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        cmp("t5_miso_async", 32'(miso), 32'd0);
        cmp("t5_busy_async", 32'(busy), 32'd0);
        cmp("t5_rx_valid_async", 32'(rx_valid), 32'd0);
        cmp("t5_rx_data_async", 32'(rx_data), 32'd0);
        ss_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_rd_ok = 1'b0; m_rx_data = '0;
        e_miso = 1'b0; e_rxv = 1'b0; e_busy = 1'b0; e_ferr = 1'b0; e_rxd = '0;
        chk_en = 1'b1;
        idle(2);
        frame(2'b11, 8'h44, RXW, 2, 12, 8'hFF, 1'b0);
        cmp("t5_rd_ok_cleared", rd_log, 32'h0);

        // Randomised transactions, biased towards read traffic
        for (int t = 0; t < 200; t++) begin
            c = 2'($urandom);
            if ($urandom_range(0, 2) == 0) c = 2'b10;
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, RXW - 1)) : RXW;
            d = int'($urandom_range(1, TO + 4));
            hold = int'($urandom_range(0, d + DW + 3));
            frame(c, PW'($urandom), ab, d, hold, DW'($urandom), 1'b0);
        end
        chk_en = 1'b0;

        // Wide, LSB-first build
        frame2(2'b00, 10'h2D1, 16'hFFFF, ml, nv, tl);
        cmp("t6_wr_nvalid", 32'(nv), 32'd1);
        cmp("t6_wr_rx_data", 32'(rx_data2), 32'h2D1);
        cmp("t6_wr_miso", 32'(ml), 32'h0);
        frame2(2'b10, 10'h155, 16'h0000, ml, nv, tl);
        cmp("t6_addr_rx_data", 32'(rx_data2), 32'h955);
        frame2(2'b11, 10'h000, 16'h8001, ml, nv, tl);
        cmp("t6_rd_rx_data", 32'(rx_data2), 32'hC00);
        cmp("t6_rd_miso", 32'(ml), 32'h8001);
        cmp("t6_rd_tail", 32'(tl), 32'd0);
        cmp("t6_busy_idle", 32'(busy2), 32'd0);
        for (int t = 0; t < 4; t++) begin
            w = DW2'($urandom);
            frame2(2'b10, PW2'($urandom), 16'h0000, ml, nv, tl);
            frame2(2'b11, PW2'($urandom), w, ml, nv, tl);
            cmp("t6_rand_miso", 32'(ml), 32'(w));
            cmp("t6_rand_nvalid", 32'(nv), 32'd1);
        end
        cmp("t6_no_frame_err", 32'(b_ferr_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
